// File: rtl/axi4lite_pkg.sv
// Shared response codes, FSM state encodings and address regions for the AXI4-Lite memory slave.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_CONSOLE,
    REGION_PASS,
    REGION_NONE
  } region_t;

endpackage

// File: rtl/axi_mem_delay.sv
// Loadable 4-bit down-counter; done is high whenever the count has reached zero.
module axi_mem_delay (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite RAM slave with programmable response latency, bench back-pressure and
// two write-only MMIO registers (console byte, test-pass flag).
module axi4lite_mem_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEM_BYTES    = 65536,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned WR_LATENCY   = 1,
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
  parameter logic [31:0] PASS_VALUE   = 32'd123456789,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    axi_awvalid,
  output logic                    axi_awready,
  input  logic [31:0]             axi_awaddr,
  input  logic [2:0]              axi_awprot,
  input  logic                    axi_wvalid,
  output logic                    axi_wready,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_bvalid,
  input  logic                    axi_bready,
  output logic [1:0]              axi_bresp,
  input  logic                    axi_arvalid,
  output logic                    axi_arready,
  input  logic [31:0]             axi_araddr,
  input  logic [2:0]              axi_arprot,
  output logic                    axi_rvalid,
  input  logic                    axi_rready,
  output logic [DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]              axi_rresp,
  output logic                    console_valid,
  output logic [7:0]              console_data,
  output logic                    tests_passed
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned MEM_WORDS  = MEM_BYTES / STRB_WIDTH;
  localparam int unsigned OFF_BITS   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_BITS   = $clog2(MEM_WORDS);
  localparam logic [31:0] ALIGN_MASK = ~(32'(STRB_WIDTH) - 32'd1);

  // RAM preloading is left to the simulation environment.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic unused_prot;
  assign unused_prot = ^{axi_awprot, axi_arprot};

  function automatic region_t decode(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & ALIGN_MASK;
    if (a < 32'(MEM_BYTES))             return REGION_RAM;
    if (a == (CONSOLE_ADDR & ALIGN_MASK)) return REGION_CONSOLE;
    if (a == (PASS_ADDR & ALIGN_MASK))    return REGION_PASS;
    return REGION_NONE;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  rd_state_t             r_state, r_state_n;
  logic                  arready_n;
  logic [31:0]           ar_addr_q, ar_addr_n;
  logic [DATA_WIDTH-1:0] rdata_n;
  logic [1:0]            rresp_n;
  logic                  rd_load, rd_done;

  wr_state_t             w_state, w_state_n;
  logic                  awready_n, wready_n;
  logic                  aw_held, aw_held_n, w_held, w_held_n;
  logic [31:0]           aw_addr_q, aw_addr_n;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_n;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_n;
  logic [1:0]            bresp_n;
  logic                  wr_load, wr_done, commit;
  region_t               w_region;

  assign w_region   = decode(aw_addr_q);
  assign axi_rvalid = (r_state == R_RESP);
  assign axi_bvalid = (w_state == W_RESP);

  axi_mem_delay u_rd_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (rd_load),
    .load_val (4'(RD_LATENCY - 1)),
    .done     (rd_done)
  );

  axi_mem_delay u_wr_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (wr_load),
    .load_val (4'(WR_LATENCY - 1)),
    .done     (wr_done)
  );

  // Read data is captured on the R_WAIT->R_RESP edge, so a write committing on that
  // same edge is not yet visible to the read.
  always_comb begin
    r_state_n = r_state;
    arready_n = 1'b0;
    ar_addr_n = ar_addr_q;
    rdata_n   = axi_rdata;
    rresp_n   = axi_rresp;
    rd_load   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (axi_arvalid && !stall) begin
          arready_n = 1'b1;
          ar_addr_n = axi_araddr;
          rd_load   = 1'b1;
          r_state_n = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_done) begin
          r_state_n = R_RESP;
          case (decode(ar_addr_q))
            REGION_RAM: begin
              rdata_n = mem[ar_addr_q[OFF_BITS +: IDX_BITS]];
              rresp_n = RESP_OKAY;
            end
            REGION_NONE: begin
              rdata_n = '0;
              rresp_n = RESP_SLVERR;
            end
            default: begin
              rdata_n = '0;
              rresp_n = RESP_OKAY;
            end
          endcase
        end
      end
      R_RESP: begin
        if (axi_rready) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // AW and W are collected independently; each channel stays closed once held.
  always_comb begin
    w_state_n = w_state;
    awready_n = 1'b0;
    wready_n  = 1'b0;
    aw_held_n = aw_held;
    w_held_n  = w_held;
    aw_addr_n = aw_addr_q;
    w_data_n  = w_data_q;
    w_strb_n  = w_strb_q;
    bresp_n   = axi_bresp;
    wr_load   = 1'b0;
    commit    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (axi_awvalid && !aw_held && !stall) begin
          awready_n = 1'b1;
          aw_held_n = 1'b1;
          aw_addr_n = axi_awaddr;
        end
        if (axi_wvalid && !w_held && !stall) begin
          wready_n = 1'b1;
          w_held_n = 1'b1;
          w_data_n = axi_wdata;
          w_strb_n = axi_wstrb;
        end
        if (aw_held_n && w_held_n) begin
          wr_load   = 1'b1;
          w_state_n = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wr_done) begin
          commit    = 1'b1;
          bresp_n   = (w_region == REGION_NONE) ? RESP_SLVERR : RESP_OKAY;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_bready) begin
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_state_n = W_IDLE;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= R_IDLE;
      axi_arready   <= 1'b0;
      ar_addr_q     <= '0;
      axi_rdata     <= '0;
      axi_rresp     <= RESP_OKAY;
      w_state       <= W_IDLE;
      axi_awready   <= 1'b0;
      axi_wready    <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      axi_bresp     <= RESP_OKAY;
      console_valid <= 1'b0;
      console_data  <= '0;
      tests_passed  <= 1'b0;
    end else begin
      r_state       <= r_state_n;
      axi_arready   <= arready_n;
      ar_addr_q     <= ar_addr_n;
      axi_rdata     <= rdata_n;
      axi_rresp     <= rresp_n;
      w_state       <= w_state_n;
      axi_awready   <= awready_n;
      axi_wready    <= wready_n;
      aw_held       <= aw_held_n;
      w_held        <= w_held_n;
      aw_addr_q     <= aw_addr_n;
      w_data_q      <= w_data_n;
      w_strb_q      <= w_strb_n;
      axi_bresp     <= bresp_n;
      console_valid <= commit && (w_region == REGION_CONSOLE);
      if (commit && (w_region == REGION_CONSOLE)) console_data <= w_data_q[7:0];
      if (commit && (w_region == REGION_PASS) && (w_data_q[31:0] == PASS_VALUE)) begin
        tests_passed <= 1'b1;
      end
    end
  end

  // RAM has no reset so contents survive a mid-transaction reset.
  always_ff @(posedge clk) begin
    if (!reset && commit && (w_region == REGION_RAM)) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb_q[i]) mem[aw_addr_q[OFF_BITS +: IDX_BITS]][i*8 +: 8] <= w_data_q[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Scoreboard bench for axi4lite_mem_slave: directed vectors plus a randomised
// stall/ready phase checked against a small word model.
module tb_axi4lite_mem_slave;
  import axi4lite_pkg::*;

  localparam int unsigned RD_LAT = 3;
  localparam int unsigned WR_LAT = 4;
  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] PASS_A = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        axi_awvalid = 1'b0, axi_awready;
  logic [31:0] axi_awaddr = '0;
  logic [2:0]  axi_awprot = '0;
  logic        axi_wvalid = 1'b0, axi_wready;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_bvalid, axi_bready = 1'b1;
  logic [1:0]  axi_bresp;
  logic        axi_arvalid = 1'b0, axi_arready;
  logic [31:0] axi_araddr = '0;
  logic [2:0]  axi_arprot = '0;
  logic        axi_rvalid, axi_rready = 1'b1;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        tests_passed;

  axi4lite_mem_slave #(
    .DATA_WIDTH (32),
    .MEM_BYTES  (65536),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .axi_awvalid   (axi_awvalid),
    .axi_awready   (axi_awready),
    .axi_awaddr    (axi_awaddr),
    .axi_awprot    (axi_awprot),
    .axi_wvalid    (axi_wvalid),
    .axi_wready    (axi_wready),
    .axi_wdata     (axi_wdata),
    .axi_wstrb     (axi_wstrb),
    .axi_bvalid    (axi_bvalid),
    .axi_bready    (axi_bready),
    .axi_bresp     (axi_bresp),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_araddr    (axi_araddr),
    .axi_arprot    (axi_arprot),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready),
    .axi_rdata     (axi_rdata),
    .axi_rresp     (axi_rresp),
    .console_valid (console_valid),
    .console_data  (console_data),
    .tests_passed  (tests_passed)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic [1:0]  bq[$];
  logic [7:0]  cq[$];
  bit          rand_ready = 1'b0, rand_stall = 1'b0, bready_hold = 1'b0;
  logic [31:0] model[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Back-pressure and ready drivers.
  initial begin
    forever begin
      @(negedge clk);
      axi_rready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      axi_bready = bready_hold ? 1'b0 : (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
      stall      = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Monitor: a handshake seen here completes on the next posedge.
  int          last_wacc = 0, last_racc = 0, rn = 0, bn = 0;
  logic        prev_rvalid = 1'b0, prev_rready = 1'b1, prev_bvalid = 1'b0, prev_bready = 1'b1;
  logic        prev_cv = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic [1:0]  prev_bresp = '0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      prev_rvalid = 1'b0;
      prev_bvalid = 1'b0;
      prev_cv     = 1'b0;
    end else begin
      if ((axi_awvalid && axi_awready) || (axi_wvalid && axi_wready)) last_wacc = cyc;
      if (axi_arvalid && axi_arready) last_racc = cyc;
      if (axi_rvalid && !prev_rvalid) check("rd_latency", 64'(cyc - last_racc), 64'(RD_LAT));
      if (axi_bvalid && !prev_bvalid) check("wr_latency", 64'(cyc - last_wacc), 64'(WR_LAT));
      if (prev_rvalid && !prev_rready) begin
        check("rvalid_hold", axi_rvalid, 1);
        check("rdata_hold", axi_rdata, prev_rdata);
      end
      if (prev_bvalid && !prev_bready) begin
        check("bvalid_hold", axi_bvalid, 1);
        check("bresp_hold", axi_bresp, prev_bresp);
      end
      if (axi_rvalid && axi_rready) begin
        if (rq_data.size() == 0) begin
          check("r_unexpected", 1, 0);
        end else begin
          check($sformatf("rdata#%0d", rn), axi_rdata, rq_data.pop_front());
          check($sformatf("rresp#%0d", rn), axi_rresp, rq_resp.pop_front());
        end
        rn++;
      end
      if (axi_bvalid && axi_bready) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else check($sformatf("bresp#%0d", bn), axi_bresp, bq.pop_front());
        bn++;
      end
      if (console_valid) begin
        check("console_pulse_len", prev_cv, 0);
        if (cq.size() == 0) check("console_unexpected", 1, 0);
        else check("console_data", console_data, cq.pop_front());
      end
      prev_rvalid = axi_rvalid;
      prev_rready = axi_rready;
      prev_rdata  = axi_rdata;
      prev_bvalid = axi_bvalid;
      prev_bready = axi_bready;
      prev_bresp  = axi_bresp;
      prev_cv     = console_valid;
    end
  end

  task automatic drive_aw(input logic [31:0] addr);
    int unsigned n;
    @(negedge clk);
    axi_awvalid = 1'b1;
    axi_awaddr  = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi_awready && n < 200);
    if (!axi_awready) fail_now("aw_handshake");
    @(negedge clk);
    axi_awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb);
    int unsigned n;
    @(negedge clk);
    axi_wvalid = 1'b1;
    axi_wdata  = data;
    axi_wstrb  = strb;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi_wready && n < 200);
    if (!axi_wready) fail_now("w_handshake");
    @(negedge clk);
    axi_wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] addr);
    int unsigned n;
    @(negedge clk);
    axi_arvalid = 1'b1;
    axi_araddr  = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi_arready && n < 200);
    if (!axi_arready) fail_now("ar_handshake");
    @(negedge clk);
    axi_arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((rq_data.size() != 0 || bq.size() != 0 || cq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      fail_now("drain");
      rq_data.delete();
      rq_resp.delete();
      bq.delete();
      cq.delete();
    end
    #2;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input int unsigned aw_lead,
                             input int unsigned w_lead);
    bq.push_back(resp);
    fork
      begin repeat (aw_lead) @(negedge clk); drive_w(data, strb); end
      begin repeat (w_lead) @(negedge clk); drive_aw(addr); end
    join
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] resp);
    issue_write(addr, data, strb, resp, 0, 0);
    wait_drain();
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    rq_data.push_back(data);
    rq_resp.push_back(resp);
    drive_ar(addr);
    wait_drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n, slot;
    logic [31:0] a, d;
    logic [3:0]  s;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", {axi_arready, axi_awready, axi_wready}, 0);
    check("rst_valid", {axi_rvalid, axi_bvalid, console_valid}, 0);
    check("rst_passed", tests_passed, 0);
    check("rst_rdata", axi_rdata, 0);
    check("rst_resp", {axi_rresp, axi_bresp}, 0);

    // Full word, byte-lane merge, empty strobe.
    axi_write(32'h100, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
    axi_read(32'h100, 32'hDEAD_BEEF, RESP_OKAY);
    axi_write(32'h104, 32'h1122_3344, 4'hF, RESP_OKAY);
    axi_write(32'h104, 32'h00AA_0000, 4'b0100, RESP_OKAY);
    axi_read(32'h104, 32'h11AA_3344, RESP_OKAY);
    axi_write(32'h104, 32'hFFFF_FFFF, 4'h0, RESP_OKAY);
    axi_read(32'h106, 32'h11AA_3344, RESP_OKAY);

    // W leads AW by 3 cycles; response held by bready low for 5 cycles.
    bready_hold = 1'b1;
    issue_write(32'h108, 32'hCAFE_F00D, 4'hF, RESP_OKAY, 0, 3);
    n = 0;
    while (!axi_bvalid && n < 100) begin @(negedge clk); n++; end
    if (!axi_bvalid) fail_now("t3_bvalid");
    for (int i = 0; i < 5; i++) begin
      check("t3_bvalid_held", axi_bvalid, 1);
      @(negedge clk);
    end
    bready_hold = 1'b0;
    wait_drain();
    axi_read(32'h108, 32'hCAFE_F00D, RESP_OKAY);

    // MMIO registers.
    cq.push_back(8'h41);
    axi_write(CON_A, 32'h0000_0041, 4'hF, RESP_OKAY);
    axi_read(CON_A, 32'h0, RESP_OKAY);
    axi_write(PASS_A, 32'd5, 4'hF, RESP_OKAY);
    check("pass_wrong_value", tests_passed, 0);
    axi_write(PASS_A, 32'd123456789, 4'hF, RESP_OKAY);
    check("pass_set", tests_passed, 1);
    axi_write(32'h10C, 32'h0BAD_F00D, 4'hF, RESP_OKAY);
    check("pass_sticky", tests_passed, 1);
    axi_read(PASS_A, 32'h0, RESP_OKAY);

    // Decode boundaries and SLVERR.
    axi_write(32'h0000_FFFC, 32'hA5A5_5A5A, 4'hF, RESP_OKAY);
    axi_read(32'h0000_FFFC, 32'hA5A5_5A5A, RESP_OKAY);
    axi_read(32'h0001_0000, 32'h0, RESP_SLVERR);
    axi_write(32'h3000_0000, 32'h1234_5678, 4'hF, RESP_SLVERR);
    axi_write(32'h0001_0100, 32'h5555_5555, 4'hF, RESP_SLVERR);
    axi_read(32'h100, 32'hDEAD_BEEF, RESP_OKAY);

    // Randomised back-pressure against the word model.
    rand_ready = 1'b1;
    rand_stall = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      model[i] = $urandom;
      axi_write(32'h200 + 32'(i * 4), model[i], 4'hF, RESP_OKAY);
    end
    for (int unsigned k = 0; k < 300; k++) begin
      slot = $urandom_range(0, 7);
      a = 32'h200 + 32'(slot * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        model[slot] = merge(model[slot], d, s);
        issue_write(a, d, s, RESP_OKAY, $urandom_range(0, 2), $urandom_range(0, 2));
        wait_drain();
      end else begin
        axi_read(a, model[slot], RESP_OKAY);
      end
    end
    rand_ready = 1'b0;
    rand_stall = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a read is waiting: response discarded, RAM retained.
    drive_ar(32'h204);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("reset_rvalid", axi_rvalid, 0);
      @(negedge clk);
    end
    check("reset_passed", tests_passed, 0);
    axi_read(32'h204, model[1], RESP_OKAY);
    axi_read(32'h100, 32'hDEAD_BEEF, RESP_OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
